// File: rtl/serial_frame_gen.sv
// Byte FIFO feeding a UART / PS/2 device-to-host frame serialiser with programmable timing.
// Optional SERIAL_FRAME_GEN_PS2_INHIBIT_EN adds host clock-inhibit handling on ps2_clk_in.
//
// state    | meaning
// S_IDLE   | waiting for a queued byte; pops it and latches mode/parity
// S_START  | start bit slot (line low)
// S_DATA   | DATA_BITS payload slots, LSB first
// S_PARITY | parity slot (skipped for UART without parity)
// S_STOP   | stop bit slot (line high); frame counted at its end
// S_GAP    | all lines high for GAP_CYCLES clocks
module serial_frame_gen #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int UART_DIV   = 868,
    parameter int PS2_HALF   = 3000,
    parameter int GAP_CYCLES = 10000,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic [1:0]                    parity_mode,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
`ifdef SERIAL_FRAME_GEN_PS2_INHIBIT_EN
    input  logic                          ps2_clk_in,
`endif
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          uart_tx,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic [15:0]                   frames_sent
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] UART_RLD = CNT_W'(UART_DIV - 1);
    localparam logic [CNT_W-1:0] PS2_RLD  = CNT_W'(2 * PS2_HALF - 1);
    localparam logic [CNT_W-1:0] PS2_MID  = CNT_W'(PS2_HALF);
    localparam logic [CNT_W-1:0] GAP_RLD  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   sh_q;
    logic                   mode_q, par_q, has_par_q;
    logic                   uart_tx_q, ps2_clk_q, ps2_data_q;
    logic [15:0]            frames_q;

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            level_q;
    logic [DATA_BITS-1:0]   head;
    logic                   push, pop, host_low, abort;
    logic [CNT_W-1:0]       slot_rld;

`ifdef SERIAL_FRAME_GEN_PS2_INHIBIT_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], ps2_clk_in};
    end
    assign host_low = ~sync_q[1];
`else
    assign host_low = 1'b0;
`endif

    assign head     = mem_q[rd_ptr_q];
    assign wr_ready = (level_q != FULL_LVL);
    assign push     = wr_valid && wr_ready;
    assign pop      = (state_q == S_IDLE) && (level_q != '0) && !(mode && host_low);
    // only the start and data slots may be cut short; parity and stop always finish
    assign abort    = mode_q && host_low && ((state_q == S_START) || (state_q == S_DATA));
    assign slot_rld = mode_q ? PS2_RLD : UART_RLD;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // {uart_tx, ps2_clk, ps2_data} at the start of a slot carrying bit v
    function automatic logic [2:0] slot_lines(input logic m, input logic v);
        return m ? {1'b1, 1'b0, v} : {v, 1'b1, 1'b1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            mode_q    <= 1'b0;
            par_q     <= 1'b0;
            has_par_q <= 1'b0;
            uart_tx_q <= 1'b1;
            ps2_clk_q <= 1'b1;
            ps2_data_q <= 1'b1;
            frames_q  <= '0;
        end else if (state_q == S_IDLE) begin
            if (pop) begin
                sh_q      <= head;
                mode_q    <= mode;
                par_q     <= (!mode && parity_mode == 2'b01) ? ^head : ~^head;
                has_par_q <= mode || (^parity_mode);
                cnt_q     <= mode ? PS2_RLD : UART_RLD;
                {uart_tx_q, ps2_clk_q, ps2_data_q} <= slot_lines(mode, 1'b0);
                state_q   <= S_START;
            end
        end else if (abort) begin
            {uart_tx_q, ps2_clk_q, ps2_data_q} <= 3'b111;
            cnt_q   <= GAP_RLD;
            state_q <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (mode_q && cnt_q == PS2_MID) ps2_clk_q <= 1'b1;
        end else begin
            cnt_q <= slot_rld;
            case (state_q)
                S_START: begin
                    state_q <= S_DATA;
                    bit_q   <= '0;
                    {uart_tx_q, ps2_clk_q, ps2_data_q} <= slot_lines(mode_q, sh_q[0]);
                end
                S_DATA: begin
                    sh_q <= sh_q >> 1;
                    if (bit_q != LAST_BIT) begin
                        bit_q <= bit_q + BW'(1);
                        {uart_tx_q, ps2_clk_q, ps2_data_q} <= slot_lines(mode_q, sh_q[1]);
                    end else if (has_par_q) begin
                        state_q <= S_PARITY;
                        {uart_tx_q, ps2_clk_q, ps2_data_q} <= slot_lines(mode_q, par_q);
                    end else begin
                        state_q <= S_STOP;
                        {uart_tx_q, ps2_clk_q, ps2_data_q} <= slot_lines(mode_q, 1'b1);
                    end
                end
                S_PARITY: begin
                    state_q <= S_STOP;
                    {uart_tx_q, ps2_clk_q, ps2_data_q} <= slot_lines(mode_q, 1'b1);
                end
                S_STOP: begin
                    frames_q <= frames_q + 16'd1;
                    {uart_tx_q, ps2_clk_q, ps2_data_q} <= 3'b111;
                    cnt_q   <= GAP_RLD;
                    state_q <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fifo_level  = level_q;
    assign busy        = (state_q != S_IDLE) || (level_q != '0);
    assign uart_tx     = uart_tx_q;
    assign ps2_clk     = ps2_clk_q;
    assign ps2_data    = ps2_data_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_serial_frame_gen.sv
// Directed bench for serial_frame_gen: UART/PS/2 framing, parity, FIFO full, reset abort,
// and host inhibit when SERIAL_FRAME_GEN_PS2_INHIBIT_EN is defined.
module tb_serial_frame_gen;

    localparam int GAP = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  parity_mode = 2'b00;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_ready, busy, uart_tx, ps2_clk, ps2_data;
    logic [2:0]  fifo_level;
    logic [15:0] frames_sent;
`ifdef SERIAL_FRAME_GEN_PS2_INHIBIT_EN
    logic        ps2_clk_in = 1'b1;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int lvl_max  = 0;

    serial_frame_gen #(
        .DATA_BITS(8), .FIFO_DEPTH(4), .UART_DIV(8), .PS2_HALF(4),
        .GAP_CYCLES(GAP), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .parity_mode(parity_mode),
        .wr_valid(wr_valid), .wr_data(wr_data),
`ifdef SERIAL_FRAME_GEN_PS2_INHIBIT_EN
        .ps2_clk_in(ps2_clk_in),
`endif
        .wr_ready(wr_ready), .fifo_level(fifo_level), .busy(busy),
        .uart_tx(uart_tx), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] d);
        @(negedge clk); wr_valid = 1'b1; wr_data = d;
        @(negedge clk); wr_valid = 1'b0;
    endtask

    task automatic wait_low(input bit ps2, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if ((ps2 ? ps2_clk : uart_tx) === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output int n);
        n = -1;
        for (int i = 1; i <= 3000 && n < 0; i++) begin
            @(negedge clk);
            if (busy === 1'b0) n = i;
        end
    endtask

    // Entered on the negedge where the start bit is first seen (cycle 0 of the frame).
    task automatic grab(input bit ps2, input int nslots, input logic [15:0] exp,
                        output logic [15:0] got, output int werr);
        int slot, ph;
        got = '0;
        werr = 0;
        for (int c = 0; c < nslots * 8; c++) begin
            if (c > 0) @(negedge clk);
            slot = c / 8;
            ph   = c % 8;
            if (ps2) begin
                if (ps2_data !== exp[slot] || ps2_clk !== ((ph >= 4) ? 1'b1 : 1'b0) || uart_tx !== 1'b1)
                    werr++;
                if (ph == 4) got[slot] = ps2_data;
            end else begin
                if (uart_tx !== exp[slot] || ps2_clk !== 1'b1 || ps2_data !== 1'b1) werr++;
                if (ph == 4) got[slot] = uart_tx;
            end
        end
    endtask

    task automatic frame(input string tag, input bit ps2, input int nslots,
                         input logic [15:0] exp, input bit perturb);
        bit ok;
        logic [15:0] got;
        int werr;
        wait_low(ps2, ok);
        check({tag, "_start"}, {31'd0, ok}, 32'd1);
        if (ok) begin
            if (perturb) begin
                parity_mode = 2'b10;
                mode = 1'b1;
            end
            grab(ps2, nslots, exp, got, werr);
            check({tag, "_bits"}, {16'd0, got}, {16'd0, exp});
            check({tag, "_wave"}, werr, 0);
        end
    endtask

    function automatic logic [15:0] uframe(input logic [7:0] d);
        return {6'd0, 1'b1, d, 1'b0};
    endfunction

    logic [7:0]  fifo_bytes [6] = '{8'hA5, 8'h3C, 8'h01, 8'hFE, 8'h80, 8'h77};
    logic [5:0]  ready_seen;
    logic [2:0]  lvl_after;
    int          n, lows;
`ifdef SERIAL_FRAME_GEN_PS2_INHIBIT_EN
    bit          ok_i;
`endif

    initial begin
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_ps2_clk", ps2_clk, 1);
        check("rst_ps2_data", ps2_data, 1);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_frames", frames_sent, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // UART, no parity, 0x41
        put(8'h41);
        frame("uart41", 0, 10, 16'h0282, 0);
        wait_idle(n);
        check("gap_busy_cycles", n, GAP + 1);
        check("frames_1", frames_sent, 1);

        // PS/2, 0x41: odd parity bit 1
        mode = 1'b1;
        put(8'h41);
        frame("ps2_41", 1, 11, 16'h0682, 0);
        wait_idle(n);
        check("idle_ps2", {31'd0, n > 0}, 1);
        check("frames_2", frames_sent, 2);

        // UART odd parity 0x03 -> 1
        mode = 1'b0;
        parity_mode = 2'b10;
        put(8'h03);
        frame("odd03", 0, 11, 16'h0606, 0);
        wait_idle(n);
        check("idle_odd", {31'd0, n > 0}, 1);

        // UART even parity 0x03 -> 0, with mode/parity changed mid-frame
        parity_mode = 2'b01;
        put(8'h03);
        frame("even03", 0, 11, 16'h0406, 1);
        wait_idle(n);
        check("idle_even", {31'd0, n > 0}, 1);
        check("frames_4", frames_sent, 4);
        mode = 1'b0;
        parity_mode = 2'b00;

        // FIFO full: six back-to-back writes, the last one refused
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    ready_seen[i] = wr_ready;
                    wr_valid = 1'b1;
                    wr_data = fifo_bytes[i];
                end
                @(negedge clk);
                wr_valid = 1'b0;
                lvl_after = fifo_level;
            end
            frame("fifo0", 0, 10, uframe(8'hA5), 0);
        join
        check("fifo_ready_seq", {26'd0, ready_seen}, 32'h1F);
        check("fifo_level_full", lvl_after, 4);
        frame("fifo1", 0, 10, uframe(8'h3C), 0);
        frame("fifo2", 0, 10, uframe(8'h01), 0);
        frame("fifo3", 0, 10, uframe(8'hFE), 0);
        frame("fifo4", 0, 10, uframe(8'h80), 0);
        wait_idle(n);
        check("idle_fifo", {31'd0, n > 0}, 1);
        check("frames_9", frames_sent, 9);
        check("level_max", lvl_max, 4);

        // Reset in the middle of the data bits with a byte still queued
        put(8'h55);
        put(8'h0F);
        repeat (20) @(negedge clk);
        check("pre_rst_line", uart_tx, 0);
        check("pre_rst_level", fifo_level, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_uart_tx", uart_tx, 1);
        check("mid_rst_ps2_clk", ps2_clk, 1);
        check("mid_rst_ps2_data", ps2_data, 1);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_frames", frames_sent, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("post_rst_quiet", lows, 0);
        check("post_rst_frames", frames_sent, 0);

`ifdef SERIAL_FRAME_GEN_PS2_INHIBIT_EN
        // Host pulls the clock low during data bit 3: frame dropped, next byte waits
        mode = 1'b1;
        put(8'hC3);
        wait_low(1, ok_i);
        check("inh_start", {31'd0, ok_i}, 1);
        wr_valid = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (33) @(negedge clk);
        ps2_clk_in = 1'b0;
        repeat (6) @(negedge clk);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) lows++;
        end
        check("inh_lines_high", lows, 0);
        check("inh_frames", frames_sent, 0);
        check("inh_held", fifo_level, 1);
        ps2_clk_in = 1'b1;
        frame("inh_next", 1, 11, 16'h06B4, 0);
        wait_idle(n);
        check("inh_idle", {31'd0, n > 0}, 1);
        check("inh_frames_after", frames_sent, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
